regs_dump_ctrl: RTL and testbench
=================================

// Module: regs_dump_ctrl
// PURPOSE
//  Initiator for the register-file ports: walks all addresses to dump register contents
//  onto a valid/ready byte stream, or bulk-loads registers from an input stream.
//  Sits beside the register file as a debug/boot engine; its address/data outputs drive the
//  register file's read port 0 and write port. The CPU's own requests are muxed outside.
// PARAMETERS
//  DATA_WIDTH  8   register / stream data width
//  ADDR_WIDTH  5   register address width
//  REG_COUNT   32  registers addressed; valid range 2..2**ADDR_WIDTH
// PORTS
//  i_CLK         in   1           clock, all state on rising edge
//  i_RSTn        in   1           asynchronous active-low reset
//  i_dump_start  in   1           start dump (sampled in IDLE only)
//  i_load_start  in   1           start load (sampled in IDLE only)
//  o_reg0        out  ADDR_WIDTH  read address to register file
//  i_data0       in   DATA_WIDTH  read data, combinational from o_reg0
//  o_reg2        out  ADDR_WIDTH  write address; 0 = no write
//  o_data2       out  DATA_WIDTH  write data
//  o_tx_valid    out  1           dump byte valid
//  o_tx_data     out  DATA_WIDTH  dump byte
//  i_tx_ready    in   1           sink accepts dump byte
//  i_ld_valid    in   1           load byte valid
//  i_ld_data     in   DATA_WIDTH  load byte
//  o_ld_ready    out  1           controller accepts load byte
//  o_busy        out  1           high in any state but IDLE
//  o_done        out  1           one-cycle pulse at end of dump or load
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, all outputs 0 (o_reg2=0 guarantees no write in reset).
//  - FSM: IDLE, DUMP_RD, DUMP_TX, DUMP_SUM (macro only), LOAD, DONE.
//  - IDLE: i_dump_start -> DUMP_RD, cnt=0; else i_load_start -> LOAD, cnt=1. Both -> dump.
//    Starts outside IDLE ignored.
//  - DUMP_RD (1 cycle): o_reg0=cnt; o_tx_data<=i_data0 registered; -> DUMP_TX.
//  - DUMP_TX: o_tx_valid=1; o_tx_data stable until i_tx_ready. On handshake: if
//    cnt==REG_COUNT-1 -> DUMP_SUM/DONE, else cnt+1 -> DUMP_RD. Min 2 cycles/byte.
//    Reg 0 dumped too (reads 0); REG_COUNT bytes total, ascending address.
//  - o_reg0 = cnt in dump states, 0 otherwise.
//  - LOAD: o_ld_ready=1. On i_ld_valid&o_ld_ready: next cycle o_reg2=cnt, o_data2=i_ld_data
//    for exactly one cycle (write lands on following edge), cnt+1. Reg 0 never written;
//    REG_COUNT-1 bytes accepted. Byte for cnt==REG_COUNT-1 -> DONE, o_ld_ready low there.
//    Back-to-back bytes allowed (one per cycle); gaps in i_ld_valid stall without writes.
//  - o_reg2 is 0 in every cycle without a pending write.
//  - DONE: o_done=1 one cycle, o_busy=1; -> IDLE. Counter never wraps: terminal compare
//    precedes increment.
//  - Async reset mid-operation: immediate return to IDLE, partial transfer abandoned,
//    no o_done, any pending write dropped (o_reg2 forced 0).
// CONFIGURATION
//  REGS_DUMP_CHECKSUM_EN defined: after last register byte, DUMP_SUM sends one extra
//    byte = sum mod 2**DATA_WIDTH of all REG_COUNT dumped bytes, same valid/ready rules,
//    then DONE. Load path unchanged.
//  Not defined: no DUMP_SUM state, no accumulator; DUMP_TX of last byte -> DONE.
// TESTING
//  1 Reset: i_RSTn=0 -> all outputs 0, o_busy=0; release -> IDLE, no o_reg2 activity.
//  2 Load: start, stream 31 bytes 0x01..0x1F back-to-back -> o_reg2=1..31 one cycle each
//    with o_data2=addr, o_done pulse after last; reg0 stays 0.
//  3 Dump after test 2, i_tx_ready=1 -> 32 bytes 0x00..0x1F in order, o_done once;
//    with REG_COUNT_SUM macro REGS_DUMP_CHECKSUM_EN extra byte 0xF0 (sum 496 mod 256).
//  4 Backpressure: i_tx_ready low 5 cycles on byte 7 -> o_tx_valid/o_tx_data held, no skip.
//  5 Both starts same cycle -> dump runs, load ignored; start pulses while busy ignored.
//  6 Reset asserted in LOAD after 10 bytes -> IDLE at once, o_reg2=0, no o_done,
//    regs 1..10 keep loaded values on fresh dump (reg file not reset).

Source files
------------

// File: rtl/regs_dump_ctrl_if.sv
// rtl/regs_dump_ctrl_if.sv - register-file port and byte-stream bundle for regs_dump_ctrl
// master = controller side, slave = register file plus stream endpoints.
interface regs_dump_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] reg0;
  logic [DATA_WIDTH-1:0] data0;
  logic [ADDR_WIDTH-1:0] reg2;
  logic [DATA_WIDTH-1:0] data2;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_ready;
  logic                  ld_valid;
  logic [DATA_WIDTH-1:0] ld_data;
  logic                  ld_ready;

  modport master (
    output reg0, reg2, data2, tx_valid, tx_data, ld_ready,
    input  data0, tx_ready, ld_valid, ld_data
  );

  modport slave (
    input  reg0, reg2, data2, tx_valid, tx_data, ld_ready,
    output data0, tx_ready, ld_valid, ld_data
  );
endinterface

// File: rtl/regs_dump_ctrl.sv
// rtl/regs_dump_ctrl.sv - register-file dump/load engine; REGS_DUMP_CHECKSUM_EN adds a trailing sum byte
// Dump streams registers 0..REG_COUNT-1; load writes registers 1..REG_COUNT-1 from a stream.
module regs_dump_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int REG_COUNT  = 32
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  input  logic             i_dump_start,
  input  logic             i_load_start,
  regs_dump_ctrl_if.master bus,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(REG_COUNT - 1);

  typedef enum logic [2:0] {
    IDLE,
    DUMP_RD,
    DUMP_TX,
`ifdef REGS_DUMP_CHECKSUM_EN
    DUMP_SUM,
`endif
    LOAD,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [ADDR_WIDTH-1:0] reg2_q, reg2_d;
  logic [DATA_WIDTH-1:0] data2_q, data2_d;
`ifdef REGS_DUMP_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
`endif

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tx_data_q <= '0;
      reg2_q    <= '0;
      data2_q   <= '0;
`ifdef REGS_DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tx_data_q <= tx_data_d;
      reg2_q    <= reg2_d;
      data2_q   <= data2_d;
`ifdef REGS_DUMP_CHECKSUM_EN
      sum_q     <= sum_d;
`endif
    end
  end

  // The terminal compare always wins over the increment, so cnt never wraps.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tx_data_d = tx_data_q;
    reg2_d    = '0;
    data2_d   = '0;
`ifdef REGS_DUMP_CHECKSUM_EN
    sum_d     = sum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_dump_start) begin
          state_d = DUMP_RD;
          cnt_d   = '0;
`ifdef REGS_DUMP_CHECKSUM_EN
          sum_d   = '0;
`endif
        end else if (i_load_start) begin
          state_d = LOAD;
          cnt_d   = ADDR_WIDTH'(1);
        end
      end
      DUMP_RD: begin
        tx_data_d = bus.data0;
        state_d   = DUMP_TX;
      end
      DUMP_TX: begin
        if (bus.tx_ready) begin
`ifdef REGS_DUMP_CHECKSUM_EN
          sum_d = sum_q + tx_data_q;
`endif
          if (cnt_q == LAST) begin
`ifdef REGS_DUMP_CHECKSUM_EN
            tx_data_d = sum_q + tx_data_q;
            state_d   = DUMP_SUM;
`else
            state_d   = DONE;
`endif
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = DUMP_RD;
          end
        end
      end
`ifdef REGS_DUMP_CHECKSUM_EN
      DUMP_SUM: begin
        if (bus.tx_ready) state_d = DONE;
      end
`endif
      LOAD: begin
        if (bus.ld_valid) begin
          reg2_d  = cnt_q;
          data2_d = bus.ld_data;
          if (cnt_q == LAST) state_d = DONE;
          else               cnt_d   = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic in_dump;
`ifdef REGS_DUMP_CHECKSUM_EN
  assign in_dump      = (state_q == DUMP_RD) || (state_q == DUMP_TX) || (state_q == DUMP_SUM);
  assign bus.tx_valid = (state_q == DUMP_TX) || (state_q == DUMP_SUM);
`else
  assign in_dump      = (state_q == DUMP_RD) || (state_q == DUMP_TX);
  assign bus.tx_valid = (state_q == DUMP_TX);
`endif

  assign bus.reg0     = in_dump ? cnt_q : '0;
  assign bus.tx_data  = tx_data_q;
  assign bus.reg2     = reg2_q;
  assign bus.data2    = data2_q;
  assign bus.ld_ready = (state_q == LOAD);
  assign o_busy       = (state_q != IDLE);
  assign o_done       = (state_q == DONE);

endmodule

// File: tb/tb_regs_dump_ctrl.sv
// tb/tb_regs_dump_ctrl.sv - directed self-checking bench for regs_dump_ctrl
module tb_regs_dump_ctrl;
  localparam int DW = 8;
  localparam int AW = 5;
  localparam int RC = 32;
`ifdef REGS_DUMP_CHECKSUM_EN
  localparam int NB = RC + 1;
`else
  localparam int NB = RC;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dump_start = 1'b0;
  logic load_start = 1'b0;
  logic busy, done;
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_wr = 0;
  int   n_done = 0;

  logic [DW-1:0] regs [RC] = '{default: 8'hA5};
  logic [DW-1:0] exp_dump [NB];
  logic [DW-1:0] got [$];

  regs_dump_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regs_dump_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_COUNT(RC)) dut (
    .i_CLK        (clk),
    .i_RSTn       (rst_n),
    .i_dump_start (dump_start),
    .i_load_start (load_start),
    .bus          (bus.master),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  // Register file model: reg 0 reads as zero and is never stored; it is not reset.
  assign bus.data0 = (bus.reg0 == '0) ? '0 : regs[bus.reg0];
  always @(posedge clk) begin
    if (bus.reg2 != '0) begin
      regs[bus.reg2] <= bus.data2;
      n_wr <= n_wr + 1;
    end
  end
  always @(negedge clk) if (done) n_done <= n_done + 1;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add_sum();
`ifdef REGS_DUMP_CHECKSUM_EN
    logic [DW-1:0] s = '0;
    for (int i = 0; i < RC; i++) s = s + exp_dump[i];
    exp_dump[RC] = s;
`endif
  endtask

  task automatic test_reset();
    cyc(); cyc();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0h want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %0h want 0", done); end
    n_cmp++; if (bus.reg0 !== '0) begin n_err++; $display("FAIL reset_reg0 got %0h want 0", bus.reg0); end
    n_cmp++; if (bus.reg2 !== '0) begin n_err++; $display("FAIL reset_reg2 got %0h want 0", bus.reg2); end
    n_cmp++; if (bus.data2 !== '0) begin n_err++; $display("FAIL reset_data2 got %0h want 0", bus.data2); end
    n_cmp++; if (bus.tx_valid !== 1'b0) begin n_err++; $display("FAIL reset_tx_valid got %0h want 0", bus.tx_valid); end
    n_cmp++; if (bus.tx_data !== '0) begin n_err++; $display("FAIL reset_tx_data got %0h want 0", bus.tx_data); end
    n_cmp++; if (bus.ld_ready !== 1'b0) begin n_err++; $display("FAIL reset_ld_ready got %0h want 0", bus.ld_ready); end
    rst_n = 1'b1;
    cyc(); cyc(); cyc();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL release_busy got %0h want 0", busy); end
    n_cmp++; if (n_wr !== 0) begin n_err++; $display("FAIL release_writes got %0d want 0", n_wr); end
  endtask

  task automatic test_load();
    int d0 = n_done;
    int w0 = n_wr;
    int bad = 0;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    n_cmp++; if ({busy, bus.ld_ready} !== 2'b11) begin n_err++; $display("FAIL load_enter busy/ready got %b want 11", {busy, bus.ld_ready}); end
    for (int k = 1; k < RC; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = DW'(k);
      cyc();
      n_cmp++;
      if ({bus.reg2, bus.data2, bus.reg0, bus.ld_ready} !== {AW'(k), DW'(k), AW'(0), (k != RC - 1)}) begin
        n_err++;
        $display("FAIL load_write_%0d got reg2=%0h data2=%0h reg0=%0h rdy=%0h want reg2=%0h data2=%0h reg0=0 rdy=%0h",
                 k, bus.reg2, bus.data2, bus.reg0, bus.ld_ready, k, k, (k != RC - 1));
      end
    end
    n_cmp++; if (done !== 1'b1) begin n_err++; $display("FAIL load_done_pulse got %0h want 1", done); end
    bus.ld_valid = 1'b0;
    cyc();
    n_cmp++; if ({busy, done, bus.reg2} !== {2'b00, AW'(0)}) begin n_err++; $display("FAIL load_exit busy/done/reg2 got %0h/%0h/%0h want 0/0/0", busy, done, bus.reg2); end
    n_cmp++; if (n_wr - w0 !== RC - 1) begin n_err++; $display("FAIL load_write_count got %0d want %0d", n_wr - w0, RC - 1); end
    n_cmp++; if (n_done - d0 !== 1) begin n_err++; $display("FAIL load_done_count got %0d want 1", n_done - d0); end
    for (int k = 1; k < RC; k++) if (regs[k] !== DW'(k)) bad++;
    n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL load_regfile_contents got %0d wrong want 0", bad); end
  endtask

  task automatic run_dump(input string tag, input int stall_at, input int stall_len, input bit with_load, input bit poke);
    int cycles = 0;
    int stall_left = stall_len;
    int d0 = n_done;
    int w0 = n_wr;
    int ldr = 0;
    logic [DW-1:0] held = '0;
    got.delete();
    bus.tx_ready = 1'b1;
    dump_start   = 1'b1;
    load_start   = with_load;
    bus.ld_valid = with_load;
    bus.ld_data  = 8'h55;
    cyc();
    dump_start = 1'b0;
    load_start = 1'b0;
    while (busy && cycles < 500) begin
      if (bus.ld_ready) ldr++;
      dump_start = poke && (cycles == 20);
      load_start = poke && (cycles == 20);
      bus.tx_ready = 1'b1;
      if (bus.tx_valid) begin
        if (got.size() == stall_at && stall_left > 0) begin
          bus.tx_ready = 1'b0;
          if (stall_left == stall_len) held = bus.tx_data;
          else begin
            n_cmp++; if (bus.tx_data !== held) begin n_err++; $display("FAIL %s_held_data got %0h want %0h", tag, bus.tx_data, held); end
          end
          stall_left--;
        end else begin
          got.push_back(bus.tx_data);
        end
      end
      cyc();
      cycles++;
    end
    dump_start   = 1'b0;
    load_start   = 1'b0;
    bus.ld_valid = 1'b0;
    n_cmp++; if (cycles >= 500) begin n_err++; $display("FAIL %s_timeout got %0d cycles want <500", tag, cycles); end
    n_cmp++; if (got.size() !== NB) begin n_err++; $display("FAIL %s_byte_count got %0d want %0d", tag, got.size(), NB); end
    for (int i = 0; i < NB && i < got.size(); i++) begin
      n_cmp++; if (got[i] !== exp_dump[i]) begin n_err++; $display("FAIL %s_byte_%0d got %0h want %0h", tag, i, got[i], exp_dump[i]); end
    end
    n_cmp++; if (n_done - d0 !== 1) begin n_err++; $display("FAIL %s_done_count got %0d want 1", tag, n_done - d0); end
    n_cmp++; if (n_wr - w0 !== 0) begin n_err++; $display("FAIL %s_stray_writes got %0d want 0", tag, n_wr - w0); end
    n_cmp++; if (ldr !== 0) begin n_err++; $display("FAIL %s_ld_ready_cycles got %0d want 0", tag, ldr); end
    if (stall_len > 0) begin
      n_cmp++; if (stall_left !== 0) begin n_err++; $display("FAIL %s_stall_seen got %0d left want 0", tag, stall_left); end
    end
    cyc();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL %s_idle_after got busy=%0h want 0", tag, busy); end
  endtask

  task automatic test_dump();
    for (int i = 0; i < RC; i++) exp_dump[i] = DW'(i);
    add_sum();
`ifdef REGS_DUMP_CHECKSUM_EN
    n_cmp++; if (exp_dump[RC] !== 8'hF0) begin n_err++; $display("FAIL dump_sum_model got %0h want f0", exp_dump[RC]); end
`endif
    run_dump("dump", -1, 0, 1'b0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_dump("bp", 7, 5, 1'b0, 1'b0);
  endtask

  task automatic test_both_starts();
    run_dump("both", -1, 0, 1'b1, 1'b1);
  endtask

  task automatic test_reset_mid_load();
    int d0 = n_done;
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      bus.ld_valid = 1'b1;
      bus.ld_data  = 8'h80 + DW'(k);
      cyc();
    end
    bus.ld_valid = 1'b0;
    n_cmp++; if (bus.reg2 !== AW'(11)) begin n_err++; $display("FAIL rst_pending_reg2 got %0h want b", bus.reg2); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, bus.ld_ready} !== 3'b000) begin n_err++; $display("FAIL rst_async busy/done/rdy got %b want 000", {busy, done, bus.ld_ready}); end
    n_cmp++; if (bus.reg2 !== '0) begin n_err++; $display("FAIL rst_async_reg2 got %0h want 0", bus.reg2); end
    cyc(); cyc();
    rst_n = 1'b1;
    cyc(); cyc();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_release_busy got %0h want 0", busy); end
    n_cmp++; if (n_done - d0 !== 0) begin n_err++; $display("FAIL rst_no_done got %0d want 0", n_done - d0); end
    exp_dump[0] = '0;
    for (int i = 1; i < RC; i++) exp_dump[i] = (i <= 10) ? 8'h80 + DW'(i) : DW'(i);
    add_sum();
    run_dump("postrst", -1, 0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.tx_ready = 1'b1;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    test_reset();
    test_load();
    test_dump();
    test_backpressure();
    test_both_starts();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
